pc_sequencer: RTL and testbench

Fetch-side controller that owns the architectural program counter and sequences instruction fetch for the RV32I core. It issues word fetches to instruction memory with a valid/ready handshake and presents each fetched instruction, with its PC, to decode. It applies branch/jump redirects and traps misaligned targets. It sits between the branch/execute logic, instruction memory and the decode stage, replacing a free-running PC register.

---
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the RV32I fetch PC, keeps one word fetch outstanding at a time, hands it to decode, applies redirects and traps misaligned targets.
// Build with PC_SEQ_PERF_EN defined to add the Fetch_Count/Stall_Count performance counters.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Redirect_Valid,
   input  logic [31:0] Redirect_Target,
   output logic        IMem_Req,
   output logic [31:0] IMem_Addr,
   input  logic        IMem_Ready,
   input  logic [31:0] IMem_RData,
   output logic        Instr_Valid,
   input  logic        Instr_Ready,
   output logic [31:0] Instr_Out,
   output logic [31:0] Instr_PC,
   output logic        Misalign_Trap,
   output logic [31:0] Trap_Addr
`ifdef PC_SEQ_PERF_EN
   ,
   output logic [31:0] Fetch_Count,
   output logic [31:0] Stall_Count
`endif
);

   typedef enum logic [1:0] {BOOT, REQ, HOLD, TRAP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] trap_addr_q, trap_addr_d;
   logic        redirect_live;

   assign redirect_live = Redirect_Valid && ((state_q == REQ) || (state_q == HOLD));

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= BOOT;
         pc_q        <= RESET_VECTOR;
         instr_q     <= 32'h0;
         ipc_q       <= 32'h0;
         trap_addr_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         ipc_q       <= ipc_d;
         trap_addr_q <= trap_addr_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      ipc_d         = ipc_q;
      trap_addr_d   = trap_addr_q;
      IMem_Req      = 1'b0;
      Instr_Valid   = 1'b0;
      Misalign_Trap = 1'b0;

      case (state_q)
         BOOT: state_d = REQ;
         REQ: begin
            IMem_Req = ~Stall;
            if (IMem_Req && IMem_Ready) begin
               instr_d = IMem_RData;
               ipc_d   = pc_q;
               state_d = HOLD;
            end
         end
         HOLD: begin
            Instr_Valid = 1'b1;
            if (Instr_Ready) begin
               pc_d    = pc_q + 32'd4;
               state_d = REQ;
            end
         end
         TRAP: begin
            Misalign_Trap = 1'b1;
            state_d       = REQ;
         end
         default: state_d = BOOT;
      endcase

      // Redirect wins over every handshake: captured data is dropped, held instruction squashed.
      if (redirect_live) begin
         instr_d = instr_q;
         ipc_d   = ipc_q;
         if (Redirect_Target[1:0] == 2'b00) begin
            pc_d    = Redirect_Target;
            state_d = REQ;
         end else begin
            trap_addr_d = Redirect_Target;
            pc_d        = TRAP_VECTOR;
            state_d     = TRAP;
         end
      end
   end

   assign IMem_Addr = pc_q;
   assign Instr_Out = instr_q;
   assign Instr_PC  = ipc_q;
   assign Trap_Addr = trap_addr_q;

`ifdef PC_SEQ_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (Instr_Valid && Instr_Ready && !Redirect_Valid)
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      if ((state_q == REQ) && Stall)
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fetch_cnt_q <= 32'h0;
         stall_cnt_q <= 32'h0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign Fetch_Count = fetch_cnt_q;
   assign Stall_Count = stall_cnt_q;
`endif

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         assert ((RESET_VECTOR[1:0] == 2'b00) && (TRAP_VECTOR[1:0] == 2'b00))
            else $error("pc_sequencer: reset/trap vectors must be word aligned");
         assert (!(IMem_Req && Instr_Valid))
            else $error("pc_sequencer: fetch request issued while an instruction is held");
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer: a transaction-level PC model predicts fetch addresses, delivered instructions and traps.
module tb_pc_sequencer;
   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Stall = 1'b0;
   logic        Redirect_Valid = 1'b0;
   logic [31:0] Redirect_Target = 32'h0;
   logic        IMem_Ready = 1'b0;
   logic [31:0] IMem_RData = 32'h0;
   logic        Instr_Ready = 1'b0;
   logic        IMem_Req, Instr_Valid, Misalign_Trap;
   logic [31:0] IMem_Addr, Instr_Out, Instr_PC, Trap_Addr;

   int checks = 0;
   int errors = 0;
   int n_deliv = 0;
   int n_trap = 0;
   int n_wrap = 0;

   logic [31:0] q_fetch[$];
   logic [31:0] q_trap[$];
   logic [63:0] q_deliv[$];

   // Reference model: next PC to fetch, one possibly-captured instruction, dead cycles pending.
   logic [31:0] m_pc, m_ipc, m_idata;
   bit          m_pending;
   int          m_bubble;

   always #5 Clk = ~Clk;

   pc_sequencer dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall),
      .Redirect_Valid(Redirect_Valid), .Redirect_Target(Redirect_Target),
      .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Ready(IMem_Ready), .IMem_RData(IMem_RData),
      .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready), .Instr_Out(Instr_Out), .Instr_PC(Instr_PC),
      .Misalign_Trap(Misalign_Trap), .Trap_Addr(Trap_Addr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = 32'h0;
      m_ipc     = 32'h0;
      m_idata   = 32'h0;
      m_pending = 1'b0;
      m_bubble  = 1;
      q_fetch.delete();
      q_trap.delete();
      q_deliv.delete();
   endtask

   task automatic quiet();
      Stall          = 1'b1;
      IMem_Ready     = 1'b0;
      Instr_Ready    = 1'b0;
      Redirect_Valid = 1'b0;
   endtask

   task automatic step(input bit easy);
      logic [31:0] tgt;
      Stall          = easy ? 1'b0 : ($urandom_range(0, 3) == 0);
      IMem_Ready     = easy ? 1'b1 : ($urandom_range(0, 9) < 6);
      Instr_Ready    = easy ? 1'b1 : ($urandom_range(0, 9) < 6);
      IMem_RData     = $urandom;
      Redirect_Valid = !easy && ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 5))
         0: tgt = 32'h0000_0040;
         1: tgt = 32'h0000_0042;
         2: tgt = 32'hFFFF_FFFC;
         3: tgt = $urandom | 32'h1;
         4: tgt = $urandom & 32'hFFFF_FFFC;
         default: tgt = $urandom;
      endcase
      Redirect_Target = tgt;

      if (m_bubble > 0) begin
         m_bubble--;
      end else if (Redirect_Valid) begin
         m_pending = 1'b0;
         if (tgt[1:0] == 2'b00) m_pc = tgt;
         else begin
            q_trap.push_back(tgt);
            m_pc     = 32'h0000_0100;
            m_bubble = 1;
         end
      end else if (m_pending) begin
         if (Instr_Ready) begin
            q_deliv.push_back({m_ipc, m_idata});
            m_pending = 1'b0;
            if (m_ipc == 32'hFFFF_FFFC) n_wrap++;
            m_pc = m_pc + 32'd4;
         end
      end else if (!Stall && IMem_Ready) begin
         q_fetch.push_back(m_pc);
         m_ipc     = m_pc;
         m_idata   = IMem_RData;
         m_pending = 1'b1;
      end
   endtask

   // Monitor: samples mid-low-phase, pops expectations whenever the DUT shows a transaction.
   initial begin
      logic [63:0] d;
      forever begin
         @(negedge Clk);
         #3;
         if (!Reset) begin
            chk("req_valid_exclusive", 32'(IMem_Req & Instr_Valid), 32'h0);
            if (Stall && IMem_Req) chk("req_under_stall", 32'(IMem_Req), 32'h0);
            if (IMem_Req && IMem_Ready && !Redirect_Valid) begin
               if (q_fetch.size() == 0) chk("unexpected_fetch_addr", IMem_Addr, 32'hxxxx_xxxx);
               else chk("fetch_addr", IMem_Addr, q_fetch.pop_front());
            end
            if (Instr_Valid && Instr_Ready && !Redirect_Valid) begin
               if (q_deliv.size() == 0) chk("unexpected_instr_pc", Instr_PC, 32'hxxxx_xxxx);
               else begin
                  d = q_deliv.pop_front();
                  chk("instr_pc", Instr_PC, d[63:32]);
                  chk("instr_out", Instr_Out, d[31:0]);
                  n_deliv++;
               end
            end
            if (Misalign_Trap) begin
               chk("trap_no_req", 32'(IMem_Req), 32'h0);
               chk("trap_pc", IMem_Addr, 32'h0000_0100);
               if (q_trap.size() == 0) chk("unexpected_trap_addr", Trap_Addr, 32'hxxxx_xxxx);
               else begin
                  chk("trap_addr", Trap_Addr, q_trap.pop_front());
                  n_trap++;
               end
            end
         end
      end
   end

   initial begin
      bit did_mid_reset = 1'b0;
      model_reset();
      repeat (2) @(negedge Clk);
      #2;
      chk("rst_imem_req", 32'(IMem_Req), 32'h0);
      chk("rst_instr_valid", 32'(Instr_Valid), 32'h0);
      chk("rst_trap", 32'(Misalign_Trap), 32'h0);
      chk("rst_imem_addr", IMem_Addr, 32'h0);
      chk("rst_instr_out", Instr_Out, 32'h0);
      chk("rst_instr_pc", Instr_PC, 32'h0);
      chk("rst_trap_addr", Trap_Addr, 32'h0);
      @(negedge Clk);
      Reset = 1'b0;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (!did_mid_reset && cyc >= 2000 && m_bubble == 0 && !m_pending) begin
            // Mid-fetch reset: request is up, then drops asynchronously.
            did_mid_reset = 1'b1;
            Stall = 1'b0; IMem_Ready = 1'b0; Instr_Ready = 1'b0; Redirect_Valid = 1'b0;
            #1;
            chk("pre_reset_req", 32'(IMem_Req), 32'h1);
            #1;
            Reset = 1'b1;
            #1;
            chk("async_reset_req", 32'(IMem_Req), 32'h0);
            chk("async_reset_pc", IMem_Addr, 32'h0);
            chk("async_reset_valid", 32'(Instr_Valid), 32'h0);
            quiet();
            @(negedge Clk);
            model_reset();
            Reset = 1'b0;
            for (int k = 0; k < 6; k++) begin
               step(1'b1);
               @(negedge Clk);
            end
         end
         step(cyc < 20);
         @(negedge Clk);
      end
      quiet();
      #4;
      chk("fetch_queue_drained", 32'(q_fetch.size()), 32'h0);
      chk("deliv_queue_drained", 32'(q_deliv.size()), 32'h0);
      chk("trap_queue_drained", 32'(q_trap.size()), 32'h0);
      checks++;
      if (n_deliv < 200 || n_trap < 5) begin
         errors++;
         $display("FAIL activity: got %0d deliveries and %0d traps, required at least 200 and 5", n_deliv, n_trap);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
